// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, issues word reads over a request/ready handshake,
// and feeds the IF/ID latch. It also holds a one-entry skid buffer and handles delayed branches.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic        if_stall_request,
    output logic [31:0] if_register_pc,
    output logic [31:0] if_instruction
);

    typedef enum logic [1:0] {StIdle, StRequest, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic        branch_take;
    logic [31:0] target_aligned;
    logic [31:0] pc_after_fetch;

    assign branch_take    = branch_flag && !stall;
    assign target_aligned = {branch_target[31:2], 2'b00};
    // A deferred branch takes effect when the delay-slot fetch completes.
    assign pc_after_fetch = pending_q ? pending_target_q : pc_q + PC_STEP;

    assign imem_read        = (state_q == StRequest);
    assign imem_addr        = pc_q;
    assign if_stall_request = (state_q == StRequest) && !imem_ready;
    assign if_register_pc   = out_pc_q;
    assign if_instruction   = out_instr_q;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        skid_pc_d        = skid_pc_q;
        skid_instr_d     = skid_instr_q;
        pending_d        = pending_q;
        pending_target_d = pending_target_q;
        out_pc_d         = out_pc_q;
        out_instr_d      = out_instr_q;

        unique case (state_q)
            StIdle: begin
                state_d = StRequest;
                if (!stall) begin
                    out_pc_d    = 32'h0;
                    out_instr_d = 32'h0;
                end
                if (branch_take) begin
                    pending_d        = 1'b1;
                    pending_target_d = target_aligned;
                end
            end
            StRequest: begin
                if (!imem_ready) begin
                    if (!stall) begin
                        out_pc_d    = 32'h0;
                        out_instr_d = 32'h0;
                    end
                    if (branch_take) begin
                        pending_d        = 1'b1;
                        pending_target_d = target_aligned;
                    end
                end else if (!stall) begin
                    out_pc_d    = pc_q;
                    out_instr_d = imem_data;
                    pc_d        = branch_take ? target_aligned : pc_after_fetch;
                    pending_d   = 1'b0;
                end else begin
                    skid_pc_d    = pc_q;
                    skid_instr_d = imem_data;
                    pc_d         = pc_after_fetch;
                    pending_d    = 1'b0;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (!stall) begin
                    out_pc_d    = skid_pc_q;
                    out_instr_d = skid_instr_q;
                    state_d     = StRequest;
                    if (branch_take) begin
                        pc_d = target_aligned;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= StIdle;
            pc_q             <= RESET_PC;
            skid_pc_q        <= 32'h0;
            skid_instr_q     <= 32'h0;
            pending_q        <= 1'b0;
            pending_target_q <= 32'h0;
            out_pc_q         <= 32'h0;
            out_instr_q      <= 32'h0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            skid_pc_q        <= skid_pc_d;
            skid_instr_q     <= skid_instr_d;
            pending_q        <= pending_d;
            pending_target_q <= pending_target_d;
            out_pc_q         <= out_pc_d;
            out_instr_q      <= out_instr_d;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Directed testbench for stage_if. Memory returns addr ^ 32'hA5A5A5A5, and every expected
// value below is worked out by hand from that pattern.
module tb_stage_if;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        if_stall_request;
    logic [31:0] if_register_pc;
    logic [31:0] if_instruction;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign imem_data = imem_addr ^ 32'hA5A5A5A5;

    stage_if dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .branch_flag      (branch_flag),
        .branch_target    (branch_target),
        .imem_read        (imem_read),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .imem_ready       (imem_ready),
        .if_stall_request (if_stall_request),
        .if_register_pc   (if_register_pc),
        .if_instruction   (if_instruction)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] addr);
        chk({tag, ".pc"}, if_register_pc, pc);
        chk({tag, ".instr"}, if_instruction, instr);
        chk({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        imem_ready = 1'b0;
        tick();
        tick();
        chk("rst.read", {31'b0, imem_read}, 32'h0);
        chk("rst.sreq", {31'b0, if_stall_request}, 32'h0);
        chk_out("rst", 32'h0, 32'h0, 32'h0);

        // Zero-wait memory: one instruction per cycle, outputs lag by one cycle.
        reset = 1'b0; imem_ready = 1'b1;
        tick();
        chk("zw0.read", {31'b0, imem_read}, 32'h1);
        chk_out("zw0", 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("zw1", 32'h0, 32'hA5A5A5A5, 32'h4);
        tick();
        chk_out("zw2", 32'h4, 32'hA5A5A5A1, 32'h8);
        tick();
        chk_out("zw3", 32'h8, 32'hA5A5A5AD, 32'hC);

        // Memory wait on address 0xC: two stall-request cycles, with bubbles on the outputs.
        imem_ready = 1'b0;
        #1 chk("wt.sreq0", {31'b0, if_stall_request}, 32'h1);
        tick();
        chk_out("wt1", 32'h0, 32'h0, 32'hC);
        chk("wt.sreq1", {31'b0, if_stall_request}, 32'h1);
        tick();
        chk_out("wt2", 32'h0, 32'h0, 32'hC);
        imem_ready = 1'b1;
        #1 chk("wt.sreq2", {31'b0, if_stall_request}, 32'h0);
        tick();
        chk_out("wt3", 32'hC, 32'hA5A5A5A9, 32'h10);

        // Stall on the same edge as ready for 0x10: the word goes to the skid buffer.
        stall = 1'b1;
        tick();
        chk("hd.read0", {31'b0, imem_read}, 32'h0);
        chk_out("hd0", 32'hC, 32'hA5A5A5A9, 32'h14);
        tick();
        chk("hd.read1", {31'b0, imem_read}, 32'h0);
        chk_out("hd1", 32'hC, 32'hA5A5A5A9, 32'h14);
        stall = 1'b0;
        tick();
        chk("hd.read2", {31'b0, imem_read}, 32'h1);
        chk_out("hd2", 32'h10, 32'hA5A5A5B5, 32'h14);

        // Branch during a zero-wait fetch: 0x14 is the delay slot, then fetch jumps to 0x100.
        branch_flag = 1'b1; branch_target = 32'h100;
        tick();
        branch_flag = 1'b0;
        chk_out("br0", 32'h14, 32'hA5A5A5B1, 32'h100);
        tick();
        chk_out("br1", 32'h100, 32'hA5A5A4A5, 32'h104);

        // Branch while the fetch is waiting: the target is deferred and its low bits are dropped.
        imem_ready = 1'b0; branch_flag = 1'b1; branch_target = 32'h203;
        tick();
        branch_flag = 1'b0;
        chk_out("pb0", 32'h0, 32'h0, 32'h104);
        tick();
        chk_out("pb1", 32'h0, 32'h0, 32'h104);
        imem_ready = 1'b1;
        tick();
        chk_out("pb2", 32'h104, 32'hA5A5A4A1, 32'h200);
        tick();
        chk_out("pb3", 32'h200, 32'hA5A5A7A5, 32'h204);

        // PC wrap: branch to 0xFFFFFFFC, and the next sequential address is 0.
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_flag = 1'b0;
        chk_out("wr0", 32'h204, 32'hA5A5A7A1, 32'hFFFF_FFFC);
        tick();
        chk_out("wr1", 32'hFFFF_FFFC, 32'h5A5A5A59, 32'h0);

        // Branch accepted from HOLD overwrites the PC that was already advanced.
        stall = 1'b1;
        tick();
        chk_out("hb0", 32'hFFFF_FFFC, 32'h5A5A5A59, 32'h4);
        stall = 1'b0; branch_flag = 1'b1; branch_target = 32'h40;
        tick();
        branch_flag = 1'b0;
        chk_out("hb1", 32'h0, 32'hA5A5A5A5, 32'h40);

        // Reset in the middle of a wait: the outstanding fetch is abandoned.
        imem_ready = 1'b0;
        tick();
        reset = 1'b1; imem_ready = 1'b1;
        tick();
        chk("rm.read", {31'b0, imem_read}, 32'h0);
        chk_out("rm0", 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        chk("rm.read1", {31'b0, imem_read}, 32'h1);
        chk_out("rm1", 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("rm2", 32'h0, 32'hA5A5A5A5, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
